// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared types and constants for the dispatch queue
// Purpose: default geometry, pointer/count widths and the buffered entry type.
// Ports: none (package).
package dispatch_pkg;

  localparam int OPCODE_W    = 7;
  localparam int PRF_W       = 6;
  localparam int DQ_DEPTH_D  = 8;
  localparam int DQ_PTR_W    = $clog2(DQ_DEPTH_D);
  localparam int DQ_CNT_W    = $clog2(DQ_DEPTH_D + 1);

  typedef struct packed {
    logic [OPCODE_W-1:0] op;
    logic                prs1_v;
    logic                prs2_v;
    logic                prd_v;
    logic [PRF_W-1:0]    prs1;
    logic [PRF_W-1:0]    prs2;
    logic [PRF_W-1:0]    prd;
  } dq_entry_t;

endpackage

// File: rtl/dispatch_queue_popcount_lane.sv
// rtl/dispatch_queue_popcount_lane.sv - valid-lane counter with packing check
// Purpose: counts set lanes of a valid vector and reports whether the lanes
//   are packed from lane 0 (no clear lane below a set lane).
// Ports: valid (in, N), cnt (out, number of set lanes), packed_ok (out).
module popcount_lane
  import dispatch_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]               valid,
  output logic [$clog2(N+1)-1:0]     cnt,
  output logic                       packed_ok
);

  localparam int CW = $clog2(N + 1);

  always_comb begin
    cnt       = '0;
    packed_ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + CW'(valid[i]);
    end
    for (int i = 1; i < N; i++) begin
      if (valid[i] && !valid[i-1]) packed_ok = 1'b0;
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - in-order buffer between rename and the CIQ
// Purpose: circular FIFO taking up to INSTR_NUM renamed instructions per cycle
//   and dispatching up to INSTR_NUM per cycle, limited by CIQ credits, each
//   dispatched lane stamped with a wrapping age.
// Ports: clk, rst (async, active-high), flush; in_valid/in_ready and per-lane
//   in_* fields from rename; ciq_free_cnt credits; out_valid, per-lane out_*
//   fields and out_age to the CIQ; dq_count occupancy.
// Macro DQ_STALL_CNT_EN: adds stall_cnt, a saturating count of cycles with
//   buffered work but zero CIQ credit (cleared by rst only).
module dispatch_queue
  import dispatch_pkg::*;
#(
  parameter int INSTR_NUM = 4,
  parameter int DQ_DEPTH  = 8,
  parameter int CIQ_DEPTH = 16,
  parameter int OPCODE    = OPCODE_W,
  parameter int PRF_WIDTH = PRF_W,
  parameter int AGE_WIDTH = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [INSTR_NUM-1:0]                  in_valid,
  output logic                                  in_ready,
  input  logic [INSTR_NUM-1:0][OPCODE-1:0]      in_op,
  input  logic [INSTR_NUM-1:0]                  in_prs1_v,
  input  logic [INSTR_NUM-1:0]                  in_prs2_v,
  input  logic [INSTR_NUM-1:0]                  in_prd_v,
  input  logic [INSTR_NUM-1:0][PRF_WIDTH-1:0]   in_prs1,
  input  logic [INSTR_NUM-1:0][PRF_WIDTH-1:0]   in_prs2,
  input  logic [INSTR_NUM-1:0][PRF_WIDTH-1:0]   in_prd,
  input  logic [$clog2(CIQ_DEPTH+1)-1:0]        ciq_free_cnt,
  output logic [INSTR_NUM-1:0]                  out_valid,
  output logic [INSTR_NUM-1:0][OPCODE-1:0]      out_op,
  output logic [INSTR_NUM-1:0]                  out_prs1_v,
  output logic [INSTR_NUM-1:0]                  out_prs2_v,
  output logic [INSTR_NUM-1:0]                  out_prd_v,
  output logic [INSTR_NUM-1:0][PRF_WIDTH-1:0]   out_prs1,
  output logic [INSTR_NUM-1:0][PRF_WIDTH-1:0]   out_prs2,
  output logic [INSTR_NUM-1:0][PRF_WIDTH-1:0]   out_prd,
  output logic [INSTR_NUM-1:0][AGE_WIDTH-1:0]   out_age,
  output logic [$clog2(DQ_DEPTH+1)-1:0]         dq_count
`ifdef DQ_STALL_CNT_EN
  ,
  output logic [31:0]                           stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DQ_DEPTH);
  localparam int CNT_W = $clog2(DQ_DEPTH + 1);
  localparam int EW    = $clog2(INSTR_NUM + 1);

  dq_entry_t             mem [DQ_DEPTH];
  logic [PTR_W-1:0]      head, tail;
  logic [CNT_W-1:0]      count;
  logic [AGE_WIDTH-1:0]  age_cnt;
  logic [EW-1:0]         enq_num;
  logic                  lanes_packed;
  logic                  enq_fire;
  logic [CNT_W-1:0]      deq_num;

  popcount_lane #(.N(INSTR_NUM)) u_popcount (
    .valid     (in_valid),
    .cnt       (enq_num),
    .packed_ok (lanes_packed)
  );

  // Readiness looks at registered occupancy only, so a full group always fits.
  assign in_ready = (CNT_W'(DQ_DEPTH) - count) >= CNT_W'(INSTR_NUM);
  assign enq_fire = in_ready && (|in_valid) && !flush;
  assign dq_count = count;

  // n = min(count, INSTR_NUM, ciq_free_cnt), forced to 0 during flush.
  always_comb begin
    deq_num = count;
    if (deq_num > CNT_W'(INSTR_NUM)) deq_num = CNT_W'(INSTR_NUM);
    if (32'(ciq_free_cnt) < 32'(deq_num)) deq_num = CNT_W'(ciq_free_cnt);
    if (flush) deq_num = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      age_cnt <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      age_cnt <= '0;
    end else begin
      head    <= head + PTR_W'(deq_num);
      tail    <= tail + (enq_fire ? PTR_W'(enq_num) : '0);
      count   <= count + (enq_fire ? CNT_W'(enq_num) : '0) - deq_num;
      age_cnt <= age_cnt + AGE_WIDTH'(deq_num);
    end
  end

  // Entry storage carries no reset; unread entries are masked at the outputs.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int i = 0; i < INSTR_NUM; i++) begin
        if (in_valid[i]) begin
          mem[tail + PTR_W'(i)] <= '{op: in_op[i], prs1_v: in_prs1_v[i],
                                     prs2_v: in_prs2_v[i], prd_v: in_prd_v[i],
                                     prs1: in_prs1[i], prs2: in_prs2[i],
                                     prd: in_prd[i]};
        end
      end
    end
  end

  always_comb begin
    dq_entry_t e;
    e = '0;
    for (int i = 0; i < INSTR_NUM; i++) begin
      out_valid[i]  = CNT_W'(i) < deq_num;
      e             = out_valid[i] ? mem[head + PTR_W'(i)] : '0;
      out_op[i]     = e.op;
      out_prs1_v[i] = e.prs1_v;
      out_prs2_v[i] = e.prs2_v;
      out_prd_v[i]  = e.prd_v;
      out_prs1[i]   = e.prs1;
      out_prs2[i]   = e.prs2;
      out_prd[i]    = e.prd;
      out_age[i]    = out_valid[i] ? age_cnt + AGE_WIDTH'(i) : '0;
    end
  end

  // Rename must present valid lanes packed from lane 0.
  assert property (@(posedge clk) disable iff (rst) (|in_valid) |-> lanes_packed);

`ifdef DQ_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((count != '0) && (ciq_free_cnt == '0) && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - self-checking bench for dispatch_queue
module tb_dispatch_queue;
  import dispatch_pkg::*;

  logic              clk = 1'b0;
  logic              rst, flush;
  logic [3:0]        in_valid;
  logic              in_ready;
  logic [3:0][6:0]   in_op;
  logic [3:0]        in_prs1_v, in_prs2_v, in_prd_v;
  logic [3:0][5:0]   in_prs1, in_prs2, in_prd;
  logic [4:0]        ciq_free_cnt;
  logic [3:0]        out_valid;
  logic [3:0][6:0]   out_op;
  logic [3:0]        out_prs1_v, out_prs2_v, out_prd_v;
  logic [3:0][5:0]   out_prs1, out_prs2, out_prd;
  logic [3:0][4:0]   out_age;
  logic [3:0]        dq_count;
`ifdef DQ_STALL_CNT_EN
  logic [31:0]       stall_cnt;
  int                m_stall = 0;
  int                s_stall;
  int                stall_base;
`endif

  dispatch_queue dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_prs1_v(in_prs1_v), .in_prs2_v(in_prs2_v), .in_prd_v(in_prd_v),
    .in_prs1(in_prs1), .in_prs2(in_prs2), .in_prd(in_prd), .ciq_free_cnt(ciq_free_cnt),
    .out_valid(out_valid), .out_op(out_op), .out_prs1_v(out_prs1_v),
    .out_prs2_v(out_prs2_v), .out_prd_v(out_prd_v), .out_prs1(out_prs1),
    .out_prs2(out_prs2), .out_prd(out_prd), .out_age(out_age), .dq_count(dq_count)
`ifdef DQ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: queue of buffered instructions plus a plain age counter.
  dq_entry_t mq[$];
  int        m_age = 0;
  int        checks = 0;
  int        failures = 0;

  logic       s_ready;
  logic [3:0] s_valid;
  int         s_count;
  int         s_age[4];

  typedef struct {
    bit         f;
    logic [3:0] v;
    int         credit;
    bit         ready;
    logic [3:0] valid;
    int         count;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic dq_entry_t out_lane(input int i);
    dq_entry_t e;
    e.op = out_op[i]; e.prs1_v = out_prs1_v[i]; e.prs2_v = out_prs2_v[i];
    e.prd_v = out_prd_v[i]; e.prs1 = out_prs1[i]; e.prs2 = out_prs2[i]; e.prd = out_prd[i];
    return e;
  endfunction

  // One cycle: drive at posedge+1, check at negedge, advance the model.
  task automatic step(input bit f, input logic [3:0] v, input int credit);
    dq_entry_t   newe[4];
    logic [31:0] r;
    int          n;
    bit          ready;
    flush = f; in_valid = v; ciq_free_cnt = 5'(credit);
    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      newe[i] = r[$bits(dq_entry_t)-1:0];
      in_op[i] = newe[i].op; in_prs1_v[i] = newe[i].prs1_v; in_prs2_v[i] = newe[i].prs2_v;
      in_prd_v[i] = newe[i].prd_v; in_prs1[i] = newe[i].prs1; in_prs2[i] = newe[i].prs2;
      in_prd[i] = newe[i].prd;
    end
    @(negedge clk);
    n = mq.size();
    if (n > 4) n = 4;
    if (credit < n) n = credit;
    if (f) n = 0;
    ready = (8 - mq.size()) >= 4;
    chk("in_ready", in_ready, ready);
    chk("dq_count", dq_count, mq.size());
    chk("out_valid", out_valid, (1 << n) - 1);
    for (int i = 0; i < n; i++) begin
      chk("out_lane", out_lane(i), mq[i]);
      chk("out_age", out_age[i], (m_age + i) % 32);
    end
    s_ready = in_ready; s_valid = out_valid; s_count = dq_count;
    for (int i = 0; i < 4; i++) s_age[i] = out_age[i];
`ifdef DQ_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
    s_stall = stall_cnt;
    if (mq.size() > 0 && credit == 0) m_stall++;
`endif
    if (f) begin
      mq.delete();
      m_age = 0;
    end else begin
      for (int i = 0; i < n; i++) void'(mq.pop_front());
      m_age = (m_age + n) % 32;
      if (ready)
        for (int i = 0; i < 4; i++) if (v[i]) mq.push_back(newe[i]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t tbl[13];
    tbl = '{
      '{0, 4'b1111, 16, 1, 4'b0000, 0},  // burst: enqueue 4
      '{0, 4'b0000, 16, 1, 4'b1111, 4},  // all 4 dispatch next cycle
      '{0, 4'b0000, 16, 1, 4'b0000, 0},  // drained
      '{0, 4'b1111,  0, 1, 4'b0000, 0},  // fill 1
      '{0, 4'b1111,  0, 1, 4'b0000, 4},  // fill 2 -> 8
      '{0, 4'b1111,  3, 0, 4'b0111, 8},  // full, credit 3
      '{0, 4'b0000, 16, 0, 4'b1111, 5},
      '{0, 4'b0000, 16, 1, 4'b0001, 1},
      '{0, 4'b1111,  0, 1, 4'b0000, 0},
      '{0, 4'b0011,  0, 1, 4'b0000, 4},
      '{1, 4'b1111, 16, 0, 4'b0000, 6},  // flush while count=6
      '{0, 4'b1111, 16, 1, 4'b0000, 0},
      '{0, 4'b0000, 16, 1, 4'b1111, 4}   // ages restart at 0
    };

    rst = 1'b1; flush = 1'b0; in_valid = '0; ciq_free_cnt = 5'd16;
    in_op = '0; in_prs1_v = '0; in_prs2_v = '0; in_prd_v = '0;
    in_prs1 = '0; in_prs2 = '0; in_prd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_dq_count", dq_count, 0);
    chk("rst_out_fields", {out_op, out_prs1, out_prd}, 0);
    chk("rst_out_age", out_age, 0);
    rst = 1'b0;

    for (int k = 0; k < 13; k++) begin
      step(tbl[k].f, tbl[k].v, tbl[k].credit);
      chk($sformatf("vec%0d_ready", k), s_ready, tbl[k].ready);
      chk($sformatf("vec%0d_valid", k), s_valid, tbl[k].valid);
      chk($sformatf("vec%0d_count", k), s_count, tbl[k].count);
    end
    chk("flush_age0", s_age[0], 0);
    chk("flush_age3", s_age[3], 3);

    // Age wrap: 30 dispatched, then the next 4 carry 30,31,0,1.
    step(1, 4'b0000, 16);
    repeat (8) step(0, 4'b1111, 16);
    step(0, 4'b0000, 2);
    step(0, 4'b1111, 0);
    step(0, 4'b0000, 16);
    chk("wrap_valid", s_valid, 4'b1111);
    chk("wrap_age0", s_age[0], 30);
    chk("wrap_age1", s_age[1], 31);
    chk("wrap_age2", s_age[2], 0);
    chk("wrap_age3", s_age[3], 1);

`ifdef DQ_STALL_CNT_EN
    step(1, 4'b0000, 16);
    step(0, 4'b0011, 0);
    stall_base = m_stall;
    repeat (5) step(0, 4'b0000, 0);
    step(1, 4'b0000, 16);
    chk("stall_five", s_stall, stall_base + 5);
    step(0, 4'b0000, 16);
    chk("stall_after_flush", s_stall, stall_base + 5);
`endif

    for (int c = 0; c < 600; c++) begin
      int k;
      int cr;
      k  = $urandom_range(0, 4);
      cr = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 16);
      step($urandom_range(0, 29) == 0, 4'((1 << k) - 1), cr);
    end

    // Asynchronous reset mid-cycle, no clock edge needed.
    step(0, 4'b1111, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", dq_count, 0);
    chk("async_rst_valid", out_valid, 4'b0000);
    chk("async_rst_ready", in_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
